// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the data-memory read-modify-write sequencer.
package mem_ctrl_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_WR     = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Byte-enable shorthands
  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_NONE = 4'b0000;

  // Defaults for the controller parameters
  localparam int unsigned DEFAULT_TIMEOUT = 16;
  localparam logic [31:0] DEFAULT_POISON  = 32'hDEADBEEF;

  // Big-endian lanes: be bit 3 holds bits 31:24, which is byte offset 0.
  function automatic logic [1:0] lane_to_offset(input logic [1:0] lane);
    return 2'd3 - lane;
  endfunction

  // Inverse mapping: single-byte enable for a byte offset within the word.
  function automatic logic [3:0] offset_to_be(input logic [1:0] offset);
    return 4'b1000 >> offset;
  endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Combinational 4-lane byte mux: each enabled lane takes the new byte,
// every other lane keeps the old byte. be bit i selects bits 8*i+7:8*i.
module byte_lane_merge (
  input  logic [3:0]  i_be,
  input  logic [31:0] i_new,
  input  logic [31:0] i_old,
  output logic [31:0] o_merged
);

  // Per-lane select between new and old data
  always_comb begin
    // NOTE: assign a full default before any conditional update so no path leaves the output unassigned (that would infer a latch).
    o_merged = i_old;
    for (int lane = 0; lane < 4; lane++) begin
      if (i_be[lane]) begin
        o_merged[8*lane +: 8] = i_new[8*lane +: 8];
      end
    end
  end

endmodule

// File: rtl/dm_rmw_controller.sv
// Sequencer between the MEM stage and a word-only handshaked data memory.
// Loads become one read, full-word stores one write, partial stores a
// read-modify-write. The pipeline is stalled while an access is in flight,
// and a wait counter abandons any transaction the memory never acknowledges.
module dm_rmw_controller
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
  parameter logic [31:0] POISON  = DEFAULT_POISON
) (
  input  logic        clk,
  input  logic        rst_n,
  // MEM-stage side
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        err,
  // Memory side
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic              r_write;
  logic [3:0]        r_be;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [31:0]       r_mem_addr;
  logic [31:0]       r_mem_wdata;   // write buffer: store data, later merged word
  logic              w_ack;
  logic              w_timeout;
  logic              w_wait_state;
  logic              w_accept;
  logic [31:0]       w_merged;
  logic              w_unused_addr_bits;

  // Word memory: the byte offset only matters through the byte enables.
  assign w_unused_addr_bits = &{1'b0, req_addr[1:0]};

  // An ack only counts while a request is actually outstanding.
  assign w_ack        = mem_ack & r_mem_req;
  assign w_wait_state = (r_state == ST_RD) | (r_state == ST_RMW_RD) | (r_state == ST_WR);
  assign w_accept     = (r_state == ST_IDLE) & req_valid;

  // Overlay the latched store lanes onto the word read back from memory.
  byte_lane_merge u_merge (
    .i_be     (r_be),
    .i_new    (r_mem_wdata),
    .i_old    (mem_rdata),
    .o_merged (w_merged)
  );

  // Next-state selection and timeout detection
  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          if (!req_write)              w_state_nxt = ST_RD;
          else if (req_be == BE_WORD)  w_state_nxt = ST_WR;
          else if (req_be == BE_NONE)  w_state_nxt = ST_DONE;
          else                         w_state_nxt = ST_RMW_RD;
        end
      end
      ST_RD, ST_RMW_RD, ST_WR: begin
        if (w_ack) begin
          w_state_nxt = (r_state == ST_RMW_RD) ? ST_WR : ST_DONE;
        end else if (r_wait_cnt == CNT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register and per-state wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state) begin
        r_wait_cnt <= '0;
      end else if (w_wait_state) begin
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      end
    end
  end

  // Request latch, write buffer, read data, error flag and registered memory outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write     <= 1'b0;
      r_be        <= BE_NONE;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      if (w_accept) begin
        r_write     <= req_write;
        r_be        <= req_be;
        r_mem_addr  <= {req_addr[31:2], 2'b00};
        r_mem_wdata <= req_wdata;
      end
      if ((r_state == ST_RMW_RD) && w_ack) begin
        r_mem_wdata <= w_merged;
      end
      if (r_state == ST_RD) begin
        if (w_ack)          r_rdata <= mem_rdata;
        else if (w_timeout) r_rdata <= POISON;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
      r_mem_req <= (w_state_nxt == ST_RD) | (w_state_nxt == ST_RMW_RD) | (w_state_nxt == ST_WR);
      r_mem_we  <= (w_state_nxt == ST_WR);
    end
  end

  // Stall is combinational on the incoming request and is forced low in reset.
  assign stall       = rst_n & (w_accept | w_wait_state);
  assign rdata_valid = (r_state == ST_DONE) & ~r_write;
  assign rdata       = r_rdata;
  assign err         = r_err;
  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;

endmodule

// File: tb/tb_dm_rmw_controller.sv
// Directed bench for dm_rmw_controller: a cycle-by-cycle vector table for
// load, partial store, waited full store and empty store, followed by
// hand-written sequences for timeout and mid-transaction reset.
module tb_dm_rmw_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [3:0]  req_be = '0;
  logic [31:0] req_wdata = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        stall, rdata_valid, err, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;

  int n_vec  = 0;
  int n_miss = 0;

  dm_rmw_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_be      (req_be),
    .req_wdata   (req_wdata),
    .stall       (stall),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .err         (err),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  // One record per clock cycle: inputs driven after the rising edge,
  // outputs checked on the following falling edge.
  typedef struct {
    string       name;
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] mrdata;
    logic        e_stall;
    logic        e_req;
    logic        e_we;
    logic [31:0] e_addr;   // compared only when e_req
    logic [31:0] e_wdata;  // compared only when e_we
    logic        e_rv;
    logic [31:0] e_rdata;  // compared only when e_rv
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input string n, input logic v, input logic w, input logic [31:0] a,
    input logic [3:0] be, input logic [31:0] wd, input logic ack,
    input logic [31:0] mr, input logic s, input logic r, input logic we,
    input logic [31:0] ea, input logic [31:0] ewd, input logic rv,
    input logic [31:0] erd, input logic er);
    vec_t t;
    t.name = n; t.valid = v; t.write = w; t.addr = a; t.be = be; t.wdata = wd;
    t.ack = ack; t.mrdata = mr; t.e_stall = s; t.e_req = r; t.e_we = we;
    t.e_addr = ea; t.e_wdata = ewd; t.e_rv = rv; t.e_rdata = erd; t.e_err = er;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic apply_vec(input vec_t v);
    logic [99:0] act, exp;
    req_valid = v.valid;
    req_write = v.write;
    req_addr  = v.addr;
    req_be    = v.be;
    req_wdata = v.wdata;
    mem_ack   = v.ack;
    mem_rdata = v.mrdata;
    @(negedge clk);
    exp = {v.e_stall, v.e_req, v.e_we, v.e_addr, v.e_wdata, v.e_rv, v.e_rdata, v.e_err};
    act = {stall, mem_req, mem_we,
           v.e_req ? mem_addr : v.e_addr,
           v.e_we ? mem_wdata : v.e_wdata,
           rdata_valid,
           v.e_rv ? rdata : v.e_rdata,
           err};
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: stall=%b req=%b we=%b addr=%h wdata=%h rv=%b rdata=%h err=%b, want stall=%b req=%b we=%b addr=%h wdata=%h rv=%b rdata=%h err=%b",
               v.name, stall, mem_req, mem_we, mem_addr, mem_wdata, rdata_valid, rdata, err,
               v.e_stall, v.e_req, v.e_we, v.e_addr, v.e_wdata, v.e_rv, v.e_rdata, v.e_err);
    end
    @(posedge clk);
    #1;
  endtask

  // Safety net in case a sequence stalls the bench entirely.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int req_cycles;

    //             name          v  w  addr          be     wdata         ack mrdata        stl req we e_addr        e_wdata       rv e_rdata       err
    // Load, zero-wait memory
    vecs.push_back(mk("ld_idle",   1, 0, 32'h104, 4'h0, 32'h0,        0, 32'h0,        1, 0, 0, 32'h0,   32'h0,        0, 32'h0,        0));
    vecs.push_back(mk("ld_rd",     1, 0, 32'h104, 4'h0, 32'h0,        1, 32'h11223344, 1, 1, 0, 32'h104, 32'h0,        0, 32'h0,        0));
    vecs.push_back(mk("ld_done",   1, 0, 32'h104, 4'h0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h0,   32'h0,        1, 32'h11223344, 0));
    // Ack with no request outstanding is ignored
    vecs.push_back(mk("stray_ack", 0, 0, 32'h0,   4'h0, 32'h0,        1, 32'hFFFFFFFF, 0, 0, 0, 32'h0,   32'h0,        0, 32'h0,        0));
    vecs.push_back(mk("stray_aft", 0, 0, 32'h0,   4'h0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h0,   32'h0,        0, 32'h0,        0));
    // SB at offset 3 (lowest lane)
    vecs.push_back(mk("sb_idle",   1, 1, 32'h203, 4'h1, 32'h000000AB, 0, 32'h0,        1, 0, 0, 32'h0,   32'h0,        0, 32'h0,        0));
    vecs.push_back(mk("sb_rmwrd",  1, 1, 32'h203, 4'h1, 32'h000000AB, 1, 32'hCAFEF00D, 1, 1, 0, 32'h200, 32'h0,        0, 32'h0,        0));
    vecs.push_back(mk("sb_wr",     1, 1, 32'h203, 4'h1, 32'h000000AB, 1, 32'h0,        1, 1, 1, 32'h200, 32'hCAFEF0AB, 0, 32'h0,        0));
    vecs.push_back(mk("sb_done",   1, 1, 32'h203, 4'h1, 32'h000000AB, 0, 32'h0,        0, 0, 0, 32'h0,   32'h0,        0, 32'h0,        0));
    // SH at offset 2 (two low lanes)
    vecs.push_back(mk("sh_idle",   1, 1, 32'h12,  4'h3, 32'h0000BEEF, 0, 32'h0,        1, 0, 0, 32'h0,   32'h0,        0, 32'h0,        0));
    vecs.push_back(mk("sh_rmwrd",  1, 1, 32'h12,  4'h3, 32'h0000BEEF, 1, 32'h01234567, 1, 1, 0, 32'h10,  32'h0,        0, 32'h0,        0));
    vecs.push_back(mk("sh_wr",     1, 1, 32'h12,  4'h3, 32'h0000BEEF, 1, 32'h0,        1, 1, 1, 32'h10,  32'h0123BEEF, 0, 32'h0,        0));
    vecs.push_back(mk("sh_done",   1, 1, 32'h12,  4'h3, 32'h0000BEEF, 0, 32'h0,        0, 0, 0, 32'h0,   32'h0,        0, 32'h0,        0));
    // SW, memory acks after three wait cycles
    vecs.push_back(mk("sw_idle",   1, 1, 32'h300, 4'hF, 32'h12345678, 0, 32'h0,        1, 0, 0, 32'h0,   32'h0,        0, 32'h0,        0));
    vecs.push_back(mk("sw_wait1",  1, 1, 32'h300, 4'hF, 32'h12345678, 0, 32'h0,        1, 1, 1, 32'h300, 32'h12345678, 0, 32'h0,        0));
    vecs.push_back(mk("sw_wait2",  1, 1, 32'h300, 4'hF, 32'h12345678, 0, 32'h0,        1, 1, 1, 32'h300, 32'h12345678, 0, 32'h0,        0));
    vecs.push_back(mk("sw_wait3",  1, 1, 32'h300, 4'hF, 32'h12345678, 0, 32'h0,        1, 1, 1, 32'h300, 32'h12345678, 0, 32'h0,        0));
    vecs.push_back(mk("sw_ack",    1, 1, 32'h300, 4'hF, 32'h12345678, 1, 32'h0,        1, 1, 1, 32'h300, 32'h12345678, 0, 32'h0,        0));
    vecs.push_back(mk("sw_done",   1, 1, 32'h300, 4'hF, 32'h12345678, 0, 32'h0,        0, 0, 0, 32'h0,   32'h0,        0, 32'h0,        0));
    // Store with no lanes enabled: no memory traffic
    vecs.push_back(mk("sb0_idle",  1, 1, 32'h400, 4'h0, 32'hFFFFFFFF, 0, 32'h0,        1, 0, 0, 32'h0,   32'h0,        0, 32'h0,        0));
    vecs.push_back(mk("sb0_done",  1, 1, 32'h400, 4'h0, 32'hFFFFFFFF, 0, 32'h0,        0, 0, 0, 32'h0,   32'h0,        0, 32'h0,        0));
    vecs.push_back(mk("idle_end",  0, 0, 32'h0,   4'h0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h0,   32'h0,        0, 32'h0,        0));

    // ---- Reset state (request presented while in reset) ----
    #2 rst_n = 1'b0;
    req_valid = 1'b1;
    #10;
    check("rst_stall",     {31'd0, stall},       32'd0);
    check("rst_mem_req",   {31'd0, mem_req},     32'd0);
    check("rst_mem_we",    {31'd0, mem_we},      32'd0);
    check("rst_mem_addr",  mem_addr,             32'd0);
    check("rst_mem_wdata", mem_wdata,            32'd0);
    check("rst_rdata",     rdata,                32'd0);
    check("rst_rvalid",    {31'd0, rdata_valid}, 32'd0);
    check("rst_err",       {31'd0, err},         32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ---- Table-driven vectors ----
    for (int i = 0; i < vecs.size(); i++) begin
      apply_vec(vecs[i]);
    end

    // ---- Load that is never acknowledged ----
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h504; req_be = 4'h0;
    mem_ack = 1'b0;
    @(negedge clk);
    check("to_idle_stall", {31'd0, stall}, 32'd1);
    req_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (!mem_req) break;
      req_cycles++;
    end
    check("to_req_cycles", req_cycles,            16);
    check("to_rvalid",     {31'd0, rdata_valid}, 32'd1);
    check("to_rdata",      rdata,                32'hDEADBEEF);
    check("to_err",        {31'd0, err},         32'd1);
    check("to_done_stall", {31'd0, stall},       32'd0);
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("to_err_sticky", {31'd0, err},         32'd1);
    check("to_rvalid_off", {31'd0, rdata_valid}, 32'd0);

    // ---- Reset in the middle of a write ----
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h600; req_be = 4'hF;
    req_wdata = 32'hA5A5A5A5; mem_ack = 1'b0;
    @(posedge clk);
    #1;
    check("rw_in_wr_req", {30'd0, mem_req, mem_we}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("rw_req_drop",  {31'd0, mem_req}, 32'd0);
    check("rw_stall_low", {31'd0, stall},   32'd0);
    check("rw_err_clear", {31'd0, err},     32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // Fresh load after release
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h706;
    mem_ack = 1'b1; mem_rdata = 32'h55AA33CC;
    @(negedge clk);
    check("rw_ld_stall", {31'd0, stall}, 32'd1);
    @(posedge clk);
    #1;
    check("rw_ld_req",  {30'd0, mem_req, mem_we}, 32'd2);
    check("rw_ld_addr", mem_addr,                  32'h704);
    @(posedge clk);
    #1;
    check("rw_ld_rvalid", {31'd0, rdata_valid}, 32'd1);
    check("rw_ld_rdata",  rdata,                32'h55AA33CC);
    check("rw_ld_err",    {31'd0, err},         32'd0);
    req_valid = 1'b0; mem_ack = 1'b0;
    @(posedge clk);
    #1;
    check("rw_ld_idle", {30'd0, stall, mem_req}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/dm_rmw_controller.md
# dm_rmw_controller

Sequencer between the MEM pipeline stage and a word-only, handshaked data memory. It turns each MEM-stage access into one or two memory transactions: a single read, a single full-word write, or a read-modify-write for partial-word stores (SB, SH, SWL, SWR). While an access is in flight it stalls the pipeline. A bounded wait counter guarantees forward progress if the memory never acknowledges.

## Interface
- `TIMEOUT`, 16: maximum cycles to wait for `mem_ack` per transaction (≥2).
- `POISON`, 32'hDEADBEEF: `rdata` value returned on timeout.
- `CLK` in 1: single clock, rising edge.
- `RESET` in 1: asynchronous, active-low reset.
- `req_valid` in 1: MEM stage presents an access.
- `req_write` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_be` in 4: store byte lanes, big-endian; bit3 = bits 31:24 = offset 0. Ignored for loads.
- `req_wdata` in 32: store data, already lane-aligned.
- `stall` out 1: hold IF..MEM pipeline registers.
- `rdata` out 32: full aligned word read, valid while `rdata_valid`.
- `rdata_valid` out 1: one-cycle pulse on load completion.
- `err` out 1: sticky timeout flag, cleared only by reset.
- `mem_req` out 1: memory request, held until ack.
- `mem_we` out 1: 1 = write.
- `mem_addr` out 32: word address, `{addr[31:2],2'b00}`.
- `mem_wdata` out 32: write word.
- `mem_ack` in 1: memory completes the current request this cycle.
- `mem_rdata` in 32: read word, valid with `mem_ack` on reads.

## Operation
- States: IDLE, RD, RMW_RD, WR, DONE.
- IDLE, `req_valid`=0: stay.
- IDLE, `req_valid`=1: latch addr, be, wdata.
  - Load → RD.
  - Store with be=4'b1111 → WR, buffer = wdata.
  - Store with be=4'b0000 → DONE, no memory traffic.
  - Other store → RMW_RD.
- RD: `mem_req`=1, `mem_we`=0. On `mem_ack`: capture `mem_rdata` into `rdata` → DONE.
- RMW_RD: `mem_req`=1, `mem_we`=0. On `mem_ack`: buffer = per-lane mux (be lane ? wdata : mem_rdata) → WR.
- WR: `mem_req`=1, `mem_we`=1, `mem_wdata`=buffer. On `mem_ack` → DONE.
- DONE: `stall`=0; `rdata_valid`=1 if the access was a load. → IDLE unconditionally.
- `stall` = (IDLE & `req_valid`) | RD | RMW_RD | WR. This term is combinational, so the pipeline is held from the cycle the request appears.
- The MEM stage advances on the DONE edge. The next request is sampled in the following IDLE cycle, so a held request never retriggers.
- Timeout:
  - A wait counter clears on every state entry and increments each cycle in RD, RMW_RD or WR without `mem_ack`.
  - When the counter reaches TIMEOUT−1 without ack: set `err`, drop `mem_req`, go → DONE.
  - A timed-out load returns `rdata`=POISON. A timed-out store is abandoned; no write is issued.
- Request inputs are don't-care while `stall` is high; only the latched copy is used.

## Timing
- Reset values: state IDLE, `stall`=0 (forced low while RESET=0), `rdata`=0, `rdata_valid`=0, `err`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, counter 0.
- Memory outputs are registered; `mem_req` rises on the edge leaving IDLE.
- `mem_ack` is allowed in the first cycle `mem_req` is high (zero-wait memory).
- Cycles from request to pipeline advance, with zero-wait memory:
  - load / full store: 3 (IDLE, RD/WR, DONE).
  - partial store: 4 (IDLE, RMW_RD, WR, DONE).
  - be=0 store: 2.
- Each memory wait cycle adds one cycle.
- Reset mid-transaction: immediate return to IDLE; `mem_req` drops asynchronously. Memory must tolerate an abandoned request.
- `mem_ack` while `mem_req`=0 is ignored.

## Structure
- Package `mem_ctrl_pkg`:
  - state enum;
  - BE constants (BE_WORD=4'b1111, BE_NONE=4'b0000);
  - lane-to-offset mapping;
  - default POISON.
- Sub-module `byte_lane_merge`: combinational 4-lane mux (be, new, old → merged). Also reusable by the MEM stage for store-lane alignment.

## Test plan
- Load, addr 0x104, `mem_ack` same cycle, `mem_rdata`=0x11223344 → `mem_addr`=0x104, `rdata`=0x11223344 with `rdata_valid` in cycle 3, `stall` high cycles 1–2.
- SB, addr 0x203, be=0001, wdata=0x000000AB, memory word 0xCAFEF00D → RMW read then write of 0xCAFEF0AB to 0x200; `stall` high 3 cycles.
- SW, be=1111, wdata=0x12345678, memory acks after 3 wait cycles → single write, no read issued; `stall` high 5 cycles.
- Load with `mem_ack` never asserted, TIMEOUT=16 → `mem_req` drops after 16 cycles, `rdata`=0xDEADBEEF, `err`=1 and stays 1.
- Store with be=0000 → no `mem_req`, `stall` high for 1 cycle only.
- RESET pulled low mid-WR → `mem_req`, `stall` = 0 immediately; a fresh load after release completes normally.
